// File: rtl/accumulator_param.sv
// Framed valid/ready accumulator: sums MAX_CNT samples (or fewer on flush)
// with selectable signedness, runtime wrap/saturate and sticky overflow flags.
module accumulator_param #(
    parameter int WIDTH   = 8,
    parameter int ACC_W   = 16,
    parameter int MAX_CNT = 16,
    parameter int SIGNED  = 1,
    localparam int CW     = $clog2(MAX_CNT + 1)
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_clr,
    input  logic             i_sat_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_ready,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic [CW-1:0]    o_cnt,
    output logic             o_ovf,
    output logic             o_carry
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    localparam logic [ACC_W-1:0] SMIN = ACC_W'(1) << (ACC_W - 1);
    localparam logic [ACC_W-1:0] SMAX = ~SMIN;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic             carry_q;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum_full;
    logic             ovf_add;
    logic             carry_add;
    logic [ACC_W-1:0] acc_d;
    logic [CW-1:0]    cnt_d;
    logic             accept;
    logic             last;

    assign accept = i_valid && (state_q != S_DONE);
    assign last   = (cnt_q == CW'(MAX_CNT - 1));
    assign cnt_d  = cnt_q + CW'(1);

    // IDLE always adds to zero, so the first sample of a frame cannot overflow.
    always_comb begin
        base = (state_q == S_ACC) ? acc_q : '0;
        if (SIGNED != 0) ext = ACC_W'($signed(i_a));
        else             ext = ACC_W'(i_a);
        sum_full = {1'b0, base} + {1'b0, ext};
        if (SIGNED != 0) begin
            ovf_add   = (base[ACC_W-1] == ext[ACC_W-1]) &&
                        (sum_full[ACC_W-1] != base[ACC_W-1]);
            carry_add = 1'b0;
        end else begin
            ovf_add   = sum_full[ACC_W];
            carry_add = sum_full[ACC_W];
        end
        acc_d = sum_full[ACC_W-1:0];
        if (ovf_add && i_sat_en) begin
            if (SIGNED != 0) acc_d = base[ACC_W-1] ? SMIN : SMAX;
            else             acc_d = '1;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (i_clr) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        cnt_q   <= CW'(1);
                        ovf_q   <= ovf_add;
                        carry_q <= carry_add;
                        state_q <= (MAX_CNT == 1) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_q | ovf_add;
                        carry_q <= carry_q | carry_add;
                    end
                    if ((accept && last) || i_flush) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_q <= S_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        carry_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (state_q != S_DONE);
    assign o_valid = (state_q == S_DONE);
    assign o_sum   = acc_q;
    assign o_cnt   = cnt_q;
    assign o_ovf   = ovf_q;
    assign o_carry = carry_q;

endmodule

// File: tb/tb_accumulator_param.sv
// Scoreboard bench for accumulator_param: three parameterisations share a clock,
// expected results are queued at stimulus time and popped by per-DUT monitors.
module tb_accumulator_param;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
        logic        carry;
    } res_t;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    res_t q0[$];
    res_t q1[$];
    res_t q2[$];

    // DUT0: defaults except MAX_CNT=4
    logic        clr0 = 0, sat0 = 0, valid0 = 0, flush0 = 0, ready0 = 1;
    logic [7:0]  a0 = '0;
    logic        oready0, ovalid0, oovf0, ocarry0;
    logic [15:0] osum0;
    logic [2:0]  ocnt0;

    accumulator_param #(.WIDTH(8), .ACC_W(16), .MAX_CNT(4), .SIGNED(1)) u_dut0 (
        .i_clk(clk), .ni_rst(rst_n), .i_clr(clr0), .i_sat_en(sat0),
        .i_valid(valid0), .i_a(a0), .o_ready(oready0), .i_flush(flush0),
        .o_valid(ovalid0), .i_ready(ready0), .o_sum(osum0), .o_cnt(ocnt0),
        .o_ovf(oovf0), .o_carry(ocarry0)
    );

    // DUT1: unsigned, 8-bit accumulator
    logic        sat1 = 0, valid1 = 0;
    logic [7:0]  a1 = '0;
    logic        oready1, ovalid1, oovf1, ocarry1;
    logic [7:0]  osum1;
    logic [2:0]  ocnt1;

    accumulator_param #(.WIDTH(8), .ACC_W(8), .MAX_CNT(4), .SIGNED(0)) u_dut1 (
        .i_clk(clk), .ni_rst(rst_n), .i_clr(1'b0), .i_sat_en(sat1),
        .i_valid(valid1), .i_a(a1), .o_ready(oready1), .i_flush(1'b0),
        .o_valid(ovalid1), .i_ready(1'b1), .o_sum(osum1), .o_cnt(ocnt1),
        .o_ovf(oovf1), .o_carry(ocarry1)
    );

    // DUT2: signed, 8-bit accumulator, 2-sample frames
    logic        sat2 = 0, valid2 = 0;
    logic [7:0]  a2 = '0;
    logic        oready2, ovalid2, oovf2, ocarry2;
    logic [7:0]  osum2;
    logic [1:0]  ocnt2;

    accumulator_param #(.WIDTH(8), .ACC_W(8), .MAX_CNT(2), .SIGNED(1)) u_dut2 (
        .i_clk(clk), .ni_rst(rst_n), .i_clr(1'b0), .i_sat_en(sat2),
        .i_valid(valid2), .i_a(a2), .o_ready(oready2), .i_flush(1'b0),
        .o_valid(ovalid2), .i_ready(1'b1), .o_sum(osum2), .o_cnt(ocnt2),
        .o_ovf(oovf2), .o_carry(ocarry2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic [15:0] s, input logic [7:0] c,
                       input logic o, input logic cy, input res_t e);
        chk({tag, "_sum"}, 32'(s), 32'(e.sum));
        chk({tag, "_cnt"}, 32'(c), 32'(e.cnt));
        chk({tag, "_ovf"}, 32'(o), 32'(e.ovf));
        chk({tag, "_carry"}, 32'(cy), 32'(e.carry));
    endtask

    task automatic unexpected(input string tag);
        tests++;
        fails++;
        $display("FAIL %s: got o_valid=1 expected no pending result", tag);
    endtask

    // Monitors: compare every cycle a result is presented, pop on handshake
    always @(negedge clk) begin
        if (rst_n && ovalid0) begin
            if (q0.size() == 0) unexpected("mon0");
            else begin
                cmp("mon0", osum0, 8'(ocnt0), oovf0, ocarry0, q0[0]);
                if (ready0) void'(q0.pop_front());
            end
        end
        if (rst_n && ovalid1) begin
            if (q1.size() == 0) unexpected("mon1");
            else begin
                cmp("mon1", 16'(osum1), 8'(ocnt1), oovf1, ocarry1, q1[0]);
                void'(q1.pop_front());
            end
        end
        if (rst_n && ovalid2) begin
            if (q2.size() == 0) unexpected("mon2");
            else begin
                cmp("mon2", 16'(osum2), 8'(ocnt2), oovf2, ocarry2, q2[0]);
                void'(q2.pop_front());
            end
        end
    end

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic wait_q(input int id);
        int n = 0;
        while (qsize(id) != 0 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("drain%0d", id), 32'(qsize(id)), 32'd0);
    endtask

    task automatic exp_push(input int id, input logic [15:0] s, input logic [7:0] c,
                            input logic o, input logic cy);
        res_t r;
        r.sum = s; r.cnt = c; r.ovf = o; r.carry = cy;
        case (id)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic send0(input logic [7:0] v, input logic fl = 1'b0);
        valid0 = 1; a0 = v; flush0 = fl;
        @(posedge clk); #1;
        valid0 = 0; flush0 = 0;
    endtask

    task automatic send1(input logic [7:0] v);
        valid1 = 1; a1 = v;
        @(posedge clk); #1;
        valid1 = 0;
    endtask

    task automatic send2(input logic [7:0] v);
        valid2 = 1; a2 = v;
        @(posedge clk); #1;
        valid2 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ovalid0), 0);
        chk("rst_sum", 32'(osum0), 0);
        chk("rst_cnt", 32'(ocnt0), 0);
        chk("rst_ovf", 32'(oovf0), 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst_ready0", 32'(oready0), 1);
        chk("rst_ready1", 32'(oready1), 1);
        chk("rst_ready2", 32'(oready2), 1);

        // Basic frame: 10 - 3 + 7 + 1
        exp_push(0, 16'd15, 8'd4, 0, 0);
        send0(8'd10); send0(8'hFD); send0(8'd7); send0(8'd1);
        chk("basic_valid_latency", 32'(ovalid0), 1);
        wait_q(0);
        chk("basic_back_idle", 32'(oready0), 1);

        // Backpressure: result held while a sample of 9 is offered
        ready0 = 0;
        exp_push(0, 16'd15, 8'd4, 0, 0);
        send0(8'd10); send0(8'hFD); send0(8'd7); send0(8'd1);
        valid0 = 1; a0 = 8'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_ready", 32'(oready0), 0);
        end
        valid0 = 0;
        ready0 = 1;
        wait_q(0);
        exp_push(0, 16'd4, 8'd4, 0, 0);
        send0(8'd1); send0(8'd1); send0(8'd1); send0(8'd1);
        wait_q(0);

        // Flush with a sample in the same cycle
        exp_push(0, 16'd18, 8'd3, 0, 0);
        send0(8'd5); send0(8'd6); send0(8'd7, 1'b1);
        chk("flush_valid", 32'(ovalid0), 1);
        wait_q(0);

        // Flush alone in IDLE produces nothing
        flush0 = 1;
        @(posedge clk); #1;
        flush0 = 0;
        @(posedge clk); #1;
        chk("idle_flush_valid", 32'(ovalid0), 0);
        chk("idle_flush_ready", 32'(oready0), 1);

        // Clear aborts a partial frame and discards a simultaneous sample
        send0(8'd3); send0(8'd4);
        clr0 = 1; valid0 = 1; a0 = 8'd50;
        @(posedge clk); #1;
        clr0 = 0; valid0 = 0;
        chk("clr_valid", 32'(ovalid0), 0);
        chk("clr_cnt", 32'(ocnt0), 0);
        chk("clr_sum", 32'(osum0), 0);
        exp_push(0, 16'd4, 8'd4, 0, 0);
        send0(8'd1); send0(8'd1); send0(8'd1); send0(8'd1);
        wait_q(0);

        // Unsigned 8-bit: 100+100+50+10 carries out
        exp_push(1, 16'd4, 8'd4, 1, 1);
        send1(8'd100); send1(8'd100); send1(8'd50); send1(8'd10);
        wait_q(1);
        sat1 = 1;
        exp_push(1, 16'd255, 8'd4, 1, 1);
        send1(8'd100); send1(8'd100); send1(8'd50); send1(8'd10);
        wait_q(1);

        // Signed 8-bit: positive overflow wrap/saturate, negative saturate
        exp_push(2, 16'h0096, 8'd2, 1, 0);
        send2(8'd100); send2(8'd50);
        wait_q(2);
        sat2 = 1;
        exp_push(2, 16'h007F, 8'd2, 1, 0);
        send2(8'd100); send2(8'd50);
        wait_q(2);
        exp_push(2, 16'h0080, 8'd2, 1, 0);
        send2(8'h9C); send2(8'hCE);
        wait_q(2);

        // Async reset while a result is held
        ready0 = 0;
        send0(8'd1); send0(8'd2); send0(8'd3); send0(8'd4);
        chk("ar_pre_valid", 32'(ovalid0), 1);
        chk("ar_pre_sum", 32'(osum0), 10);
        #1 rst_n = 0;
        #1;
        chk("ar_valid", 32'(ovalid0), 0);
        chk("ar_sum", 32'(osum0), 0);
        chk("ar_cnt", 32'(ocnt0), 0);
        @(posedge clk); #3;
        rst_n = 1;
        ready0 = 1;
        @(posedge clk); #1;
        chk("ar_ready", 32'(oready0), 1);
        chk("ar_post_valid", 32'(ovalid0), 0);

        chk("final_q0", 32'(q0.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accumulator_param.md
Name: accumulator_param

Overview:
Parametrised successor to the team's 8-bit accumulator. It sums a framed stream of WIDTH-bit samples into an ACC_W-bit accumulator under a valid/ready handshake. Each result is emitted after MAX_CNT samples, or earlier on flush. Signed or unsigned arithmetic is selected by parameter; wrap or saturate is selected at runtime. Overflow/carry flags are sticky per frame. It sits between a sample producer and a consumer that may apply backpressure.

Parameters:
WIDTH, 8, input sample width in bits
ACC_W, 16, accumulator/result width; must be >= WIDTH
MAX_CNT, 16, samples per frame; must be >= 1
SIGNED, 1, 1 = two's-complement sign-extension and signed overflow; 0 = zero-extension and unsigned carry
CW, $clog2(MAX_CNT+1), derived localparam, width of sample counter

Ports:
i_clk  in  1  clock, rising edge
ni_rst  in  1  reset, asynchronous, active-low
i_clr  in  1  synchronous clear, abort current frame
i_sat_en  in  1  1 = saturate on overflow, 0 = wrap; sampled on every accepted add
i_valid  in  1  input sample valid
i_a  in  WIDTH  input sample
o_ready  out  1  block can accept a sample
i_flush  in  1  close the current partial frame early
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_sum  out  ACC_W  frame result
o_cnt  out  CW  number of samples in result
o_ovf  out  1  sticky: any add in this frame overflowed the representable range
o_carry  out  1  sticky: unsigned carry out of bit ACC_W-1; always 0 when SIGNED=1

Behaviour:
- Reset (ni_rst=0, async): state IDLE, accumulator=0, count=0, o_sum=0, o_cnt=0, o_ovf=0, o_carry=0, o_valid=0. o_ready=1 once reset releases.
- o_ready = 1 in IDLE and ACC, 0 in DONE. o_valid = 1 only in DONE. Both are decoded from the registered state.
- An accept occurs when i_valid && o_ready on a rising edge.
- Extend i_a to ACC_W: sign-extend if SIGNED=1, zero-extend otherwise. Compute the sum in ACC_W+1 bits.
- Signed overflow: both operands have the same sign and the result sign differs. Saturate to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Unsigned overflow: carry out = 1. Saturate to 2^ACC_W-1.
- Wrap mode keeps the low ACC_W bits. The stored accumulator is the saturated or wrapped value; later adds start from it.
- o_ovf/o_carry are set on any overflowing add in the frame, regardless of i_sat_en.
- FSM states:
  - IDLE: accumulator and flags are cleared. An accept loads acc = 0 + ext(i_a) and sets count = 1. Next state is DONE if MAX_CNT==1, otherwise ACC. i_flush is ignored in IDLE.
  - ACC: an accept sets acc += ext(i_a) and count++. If this is the MAX_CNT-th sample, go to DONE. If i_flush=1, go to DONE; a sample accepted in the same cycle is included first. Otherwise stay in ACC.
  - DONE: o_sum, o_cnt, o_ovf and o_carry are registered and held stable. i_valid and i_flush are ignored. When i_ready=1, go to IDLE and clear the accumulator and flags. i_ready=0 holds DONE indefinitely.
- Latency: o_valid rises on the edge that accepts the final sample (or the flush edge), so it is visible the cycle after that accept. The earliest next accept is the cycle after the result handshake (no same-cycle turnaround).
- i_clr: synchronous, priority below reset and above all else. It forces IDLE, sets accumulator/count/flags to 0 and drops o_valid. A sample or flush presented in the same cycle is discarded.
- Async reset mid-frame or mid-DONE: all state is lost immediately; no partial result is emitted.
- o_cnt reaches MAX_CNT for full frames and can equal MAX_CNT at its CW width without wrap.

Test Plan:
- Defaults (SIGNED=1, ACC_W=16, MAX_CNT=4), accept 10, -3, 7, 1 back-to-back -> o_valid=1 the cycle after the 4th accept; o_sum=15, o_cnt=4, o_ovf=0; returns to IDLE after i_ready.
- SIGNED=0, WIDTH=8, ACC_W=8, MAX_CNT=4, inputs 100, 100, 50, 10 with i_sat_en=0 -> o_sum=4, o_carry=1, o_ovf=1. Same with i_sat_en=1 -> o_sum=255.
- SIGNED=1, ACC_W=8, MAX_CNT=2, inputs 100, 50 -> wrap gives o_sum=-106 (0x96), o_ovf=1; saturate gives o_sum=127. Inputs -100, -50 with saturate -> o_sum=-128.
- Backpressure: result 15 held with i_ready=0 for 5 cycles while i_valid=1 with value 9 -> o_sum stays 15, o_ready=0, the 9 is not accumulated; after i_ready, next frame starts at 0.
- Flush: accept 5, 6, then i_flush with a sample of 7 in the same cycle -> o_sum=18, o_cnt=3. i_flush alone in IDLE -> no o_valid.
- i_clr after 2 samples (values 3, 4), then 4 samples of 1 -> o_sum=4, o_cnt=4. Async reset asserted in DONE -> o_valid=0 and o_sum=0 immediately.
